// File: rtl/apb_master.sv
// APB3 requester: converts a valid/ready command into one APB transfer at a time.
// Optional ACCESS-phase timeout abort is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  // command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response side
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // APB requester signals
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  if (TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  abort;

  assign cmd_ready = (state_q == StIdle);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Counts ACCESS cycles that saw PREADY low; abort fires on the cycle the count hits the limit.
  always_comb begin
    cnt_d = cnt_q;
    abort = 1'b0;
    if (state_q == StIdle && cmd_valid) begin
      cnt_d = '0;
    end else if (state_q == StAccess && !PREADY) begin
      cnt_d = cnt_q + 1'b1;
      abort = (cnt_d == CntW'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_write ? cmd_wdata : '0;
          psel_d   = 1'b1;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        state_d   = StAccess;
      end
      StAccess: begin
        // PREADY wins over a coincident timeout: the transfer completes normally.
        if (PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
          state_d     = StIdle;
        end else if (abort) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= StIdle;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign PADDR     = paddr_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed plan items plus randomized transfers against a completer
// memory model and spec-derived cycle timing.
`timescale 1ns/1ps
module tb_apb_master;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] PADDR;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [DW-1:0] PWDATA, PRDATA;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] ref_mem [16];

  apb_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PADDR    (PADDR),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200us;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // One transfer: accept, SETUP, `waits` wait states, completion; checks every cycle.
  task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] rdata, input int waits, input logic err);
    logic [DW-1:0] exp_pwdata;
    exp_pwdata = wr ? wdata : '0;
    chk("idle_ready", cmd_ready, 1);
    chk("idle_psel", PSEL, 0);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    step();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    chk("setup_psel", PSEL, 1);
    chk("setup_penable", PENABLE, 0);
    chk("setup_paddr", PADDR, addr);
    chk("setup_pwrite", PWRITE, wr);
    chk("setup_pwdata", PWDATA, exp_pwdata);
    chk("setup_ready", cmd_ready, 0);
    chk("setup_rsp", rsp_valid, 0);
    step();
    for (int w = 0; w <= waits; w++) begin
      PREADY  = (w == waits);
      PRDATA  = (w == waits) ? rdata : $urandom;
      PSLVERR = (w == waits) ? err : 1'($urandom);
      chk("acc_psel", PSEL, 1);
      chk("acc_penable", PENABLE, 1);
      chk("acc_paddr", PADDR, addr);
      chk("acc_pwdata", PWDATA, exp_pwdata);
      chk("acc_rsp", rsp_valid, 0);
      step();
    end
    PREADY  = 1'b0;
    PSLVERR = 1'($urandom);
    PRDATA  = $urandom;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, wr ? '0 : rdata);
    chk("rsp_err", rsp_err, err);
    chk("rsp_psel", PSEL, 0);
    chk("rsp_penable", PENABLE, 0);
    chk("rsp_ready", cmd_ready, 1);
  endtask

  initial begin
    int sent, rsps, last_rsp, seen, lat;
    logic acc;
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = '0;
    foreach (ref_mem[i]) ref_mem[i] = $urandom;

    // Reset values, and no acceptance while reset is held.
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = 32'hFFFF_FFF0;
    step();
    chk("rst_no_accept", PSEL, 0);
    cmd_valid = 1'b0;
    #1 PRESETn = 1'b1;
    step();
    chk("post_rst_psel", PSEL, 0);

    // Directed plan items; the error read is followed by a command in its rsp_valid cycle.
    do_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    do_xfer(1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678, 3, 1'b0);
    do_xfer(1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 1, 1'b1);
    do_xfer(1'b1, 32'h0000_0024, 32'h5555_AAAA, 32'h0, 2, 1'b0);
    step();
    chk("rsp_one_cycle", rsp_valid, 0);

    // Back-to-back writes with cmd_valid held high and PREADY tied high.
    PREADY    = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h100;
    cmd_wdata = 32'hA000_0000;
    sent = 0;
    rsps = 0;
    last_rsp = 0;
    for (int cyc = 0; cyc < 40 && rsps < 4; cyc++) begin
      acc = cmd_valid && cmd_ready;
      if (cmd_ready) chk("b2b_idle_gap", PSEL, 0);
      step();
      if (rsp_valid) begin
        if (rsps > 0) chk("b2b_rsp_spacing", 64'(cyc - last_rsp), 3);
        chk("b2b_rsp_err", rsp_err, 0);
        last_rsp = cyc;
        rsps++;
      end
      if (acc) begin
        chk("b2b_paddr", PADDR, 32'h100 + 32'(sent * 4));
        chk("b2b_pwdata", PWDATA, 32'hA000_0000 + 32'(sent));
        sent++;
        if (sent == 4) begin
          cmd_valid = 1'b0;
        end else begin
          cmd_addr  = 32'h100 + 32'(sent * 4);
          cmd_wdata = 32'hA000_0000 + 32'(sent);
        end
      end
    end
    chk("b2b_sent", sent, 4);
    chk("b2b_rsps", rsps, 4);
    PREADY = 1'b0;
    step();

    // Reset pulsed during ACCESS: outputs drop at once and the transfer is lost.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0008;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("prst_acc_psel", PSEL, 1);
    chk("prst_acc_penable", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("prst_psel", PSEL, 0);
    chk("prst_penable", PENABLE, 0);
    chk("prst_rsp", rsp_valid, 0);
    chk("prst_paddr", PADDR, 0);
    @(posedge PCLK);
    #2 PRESETn = 1'b1;
    step();
    PREADY = 1'b1;
    PRDATA = 32'h0BAD_0BAD;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid || PSEL) seen++;
      step();
    end
    chk("prst_no_rsp", seen, 0);
    PREADY = 1'b0;
    do_xfer(1'b0, 32'h0000_0008, 32'h0, 32'h7777_1111, 1, 1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
    // Timeout: abort after TO wait cycles, error with zero data.
    step();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0030;
    step();
    cmd_valid = 1'b0;
    PRDATA = 32'hFFFF_FFFF;
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      step();
      lat++;
    end
    chk("to_latency", lat, 2 + TO);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_psel", PSEL, 0);
`else
    // No timeout build: waits indefinitely, then completes when PREADY rises.
    step();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0030;
    step();
    cmd_valid = 1'b0;
    step();
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid || !PSEL || !PENABLE) seen++;
      step();
    end
    chk("nto_no_rsp", seen, 0);
    PREADY = 1'b1;
    PRDATA = 32'h3C3C_A5A5;
    step();
    PREADY = 1'b0;
    chk("nto_rsp_valid", rsp_valid, 1);
    chk("nto_rsp_rdata", rsp_rdata, 32'h3C3C_A5A5);
    chk("nto_rsp_err", rsp_err, 0);
`endif
    step();

    // Randomized transfers against the completer memory model.
    for (int t = 0; t < 40; t++) begin
      logic          wr, err;
      int            idx, waits, gap;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      wr    = 1'($urandom);
      idx   = $urandom_range(0, 15);
      addr  = 32'h4000_0000 | 32'(idx << 2);
      wdata = $urandom;
      waits = $urandom_range(0, 4);
      err   = ($urandom_range(0, 7) == 0);
      do_xfer(wr, addr, wdata, ref_mem[idx], waits, err);
      if (wr && !err) ref_mem[idx] = wdata;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        chk("rnd_gap_rsp", rsp_valid, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that turns a simple valid/ready command interface into APB3 transfers. It drives PSEL/PENABLE/PADDR/PWRITE/PWDATA to an APB completer such as the UART register slave, and returns read data and error status on a one-cycle response strobe. It sits between a host-side engine (test sequencer, DMA or CPU bridge) and the peripheral APB bus, with exactly one transfer outstanding at a time.

## Interface
- ADDR_WIDTH, 32, width of PADDR and cmd_addr
- DATA_WIDTH, 32, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort (used only with the timeout feature)

- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted on a cycle where cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data (ignored on reads)
- rsp_valid  out  1  one-cycle completion strobe; no backpressure
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and aborts
- rsp_err  out  1  PSLVERR sampled at completion, or timeout abort
- PADDR  out  ADDR_WIDTH, PSEL  out  1, PENABLE  out  1, PWRITE  out  1, PWDATA  out  DATA_WIDTH  APB request signals
- PRDATA  in  DATA_WIDTH, PREADY  in  1, PSLVERR  in  1  APB completer response

## Operation
- Three-state FSM: IDLE, SETUP, ACCESS. All APB outputs and response outputs are registered.
- cmd_ready = (state == IDLE), combinational. It reads 1 while PRESETn is low, but no command is accepted during reset.
- IDLE: on cmd_valid && cmd_ready, register cmd_addr to PADDR and cmd_write to PWRITE. Register cmd_wdata to PWDATA on a write; drive PWDATA to 0 on a read. Set PSEL=1 and go to SETUP.
- SETUP: always one cycle. Set PENABLE=1 and go to ACCESS.
- ACCESS: PADDR, PWRITE, PWDATA and PSEL are held stable. While PREADY=0, the FSM stays in ACCESS (wait states).
- ACCESS with PREADY=1:
  - Clear PSEL and PENABLE.
  - Pulse rsp_valid for one cycle.
  - rsp_rdata takes PRDATA on a read, 0 on a write.
  - rsp_err takes PSLVERR.
  - Go to IDLE.
- PRDATA and PSLVERR are sampled only on the cycle where PSEL && PENABLE && PREADY.
- Between responses, rsp_rdata and rsp_err hold their last values. They are meaningful only while rsp_valid=1.
- PADDR, PWRITE and PWDATA hold their last values in IDLE.
- The bus always spends at least one IDLE cycle between transfers (no SETUP directly after ACCESS).

## Timing
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state IDLE.
- Command accepted at edge N: PSEL=1 in cycle N+1, PENABLE=1 in cycle N+2.
- With zero wait states (PREADY=1 in cycle N+2), rsp_valid=1 and cmd_ready=1 in cycle N+3.
- Each wait state adds one cycle. Minimum command-to-command spacing is 3 cycles.
- PRESETn asserted mid-transfer: PSEL and PENABLE drop immediately (asynchronously), no response is issued, and the transfer is lost.
- A command presented in the same cycle as rsp_valid is accepted, because the FSM is already in IDLE.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) counts ACCESS cycles with PREADY=0; it clears on entry to SETUP.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0, the transfer aborts: PSEL and PENABLE clear, rsp_valid=1, rsp_err=1, rsp_rdata=0, and the FSM goes to IDLE.
  - PREADY=1 on the abort cycle completes the transfer normally; it is not an abort.
- APB_MASTER_TIMEOUT_EN undefined: no counter is built, ACCESS waits indefinitely for PREADY, and TIMEOUT_CYCLES is unused.

## Test plan
- Write 0x0000_0010 ← 0xDEAD_BEEF, PREADY tied 1 → PSEL rises 1 cycle after accept, PENABLE 2 cycles after; rsp_valid 3 cycles after with rsp_err=0; PWDATA stable = 0xDEAD_BEEF across SETUP/ACCESS.
- Read 0x0000_0004 with 3 wait states, PRDATA=0x1234_5678 on the PREADY cycle → rsp_valid 6 cycles after accept, rsp_rdata=0x1234_5678; PADDR stable throughout.
- Read with PSLVERR=1 on completion → rsp_err=1 for exactly one rsp_valid cycle; the next command is accepted on that same cycle.
- Back-to-back commands, cmd_valid held high for 4 writes → each transfer separated by ≥1 IDLE cycle, exactly 4 rsp_valid pulses, addresses in order.
- PRESETn pulsed low during ACCESS → PSEL/PENABLE/rsp_valid = 0 immediately and no response; a fresh command after release completes normally.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY held 0 → abort after 16 ACCESS cycles with rsp_err=1, rsp_rdata=0. Without the macro: no response after 100 cycles; raising PREADY then completes the transfer.
